// File: rtl/wb_mem_bridge_if.sv
// rtl/wb_mem_bridge_if.sv - Wishbone slave-side signal bundle for the memory bridge
interface wb_mem_bridge_if;
    logic [18:0] wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_mem_bridge.sv
// rtl/wb_mem_bridge.sv - 16-bit Wishbone slave to flat byte-addressed memory port bridge
// with programmable wait states, byte-lane mapping and single-cycle acknowledge.
module wb_mem_bridge #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst,
    wb_mem_bridge_if.slave wb,
    output logic [19:0]    mem_addr,
    output logic [15:0]    mem_wr_data,
    input  logic [15:0]    mem_rd_data,
    output logic           mem_we,
    output logic           mem_byte_m
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q, rdata_d;
    logic        byte_q;
    logic        we_q;
    logic [1:0]  sel_q;

    logic        req;
    logic        capture;
    logic        load_rd;
    logic        cur_we;
    logic [1:0]  cur_sel;
    logic [19:0] lane_addr;
    logic [15:0] lane_wdata;
    logic        lane_byte;

    assign req = wb.wb_cyc_i & wb.wb_stb_i;

    always_comb begin
        lane_addr  = {wb.wb_adr_i, 1'b0};
        lane_byte  = 1'b0;
        lane_wdata = wb.wb_dat_i;
        case (wb.wb_sel_i)
            2'b01: begin
                lane_byte  = 1'b1;
                lane_wdata = {8'h00, wb.wb_dat_i[7:0]};
            end
            2'b10: begin
                lane_addr  = {wb.wb_adr_i, 1'b1};
                lane_byte  = 1'b1;
                lane_wdata = {8'h00, wb.wb_dat_i[15:8]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    cnt_d   = WS;
                    state_d = (WS == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wb.wb_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the read data is sampled on the capture edge itself,
    // so the request's own lane decode must be steering the memory port then.
    assign cur_we  = capture ? wb.wb_we_i  : we_q;
    assign cur_sel = capture ? wb.wb_sel_i : sel_q;
    assign load_rd = (state_d == S_ACK) && (state_q != S_ACK) && !cur_we;

    always_comb begin
        rdata_d = 16'h0000;
        case (cur_sel)
            2'b11:   rdata_d = mem_rd_data;
            2'b01:   rdata_d = {8'h00, mem_rd_data[7:0]};
            2'b10:   rdata_d = {mem_rd_data[7:0], 8'h00};
            default: rdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 20'h00000;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            byte_q  <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                addr_q  <= lane_addr;
                wdata_q <= lane_wdata;
                byte_q  <= lane_byte;
                we_q    <= wb.wb_we_i;
                sel_q   <= wb.wb_sel_i;
            end
            if (load_rd) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign mem_addr    = (state_q == S_IDLE && req) ? lane_addr : addr_q;
    assign mem_byte_m  = (state_q == S_IDLE && req) ? lane_byte : byte_q;
    assign mem_wr_data = wdata_q;
    assign mem_we      = (state_q == S_ACK) && we_q && (sel_q != 2'b00);
    assign wb.wb_ack_o = (state_q == S_ACK);
    assign wb.wb_dat_o = rdata_q;
endmodule

// File: tb/tb_wb_mem_bridge.sv
// tb/tb_wb_mem_bridge.sv - directed bench for wb_mem_bridge at 1, 0 and 3 wait states
module tb_wb_mem_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_init;
    logic [18:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we, cyc, stb;
    int          dut_sel;

    logic [19:0] maddr [3];
    logic [15:0] mwd   [3];
    logic [15:0] mrd   [3];
    logic        mwe   [3];
    logic        mbm   [3];
    logic        ack   [3];
    logic [15:0] rdat  [3];
    logic [7:0]  mem   [3][256];

    int n_tests = 0;
    int n_fail  = 0;

    int          lat, wes;
    logic [19:0] a_addr;
    logic [15:0] a_wd, a_rd;
    logic        a_bm;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g
        wb_mem_bridge_if ifc ();
        assign ifc.wb_adr_i = adr;
        assign ifc.wb_dat_i = dat;
        assign ifc.wb_sel_i = sel;
        assign ifc.wb_we_i  = we;
        assign ifc.wb_cyc_i = cyc && (dut_sel == k);
        assign ifc.wb_stb_i = stb && (dut_sel == k);
        assign ack[k]  = ifc.wb_ack_o;
        assign rdat[k] = ifc.wb_dat_o;
        assign mrd[k]  = mbm[k] ? {{8{mem[k][maddr[k][7:0]][7]}}, mem[k][maddr[k][7:0]]}
                                : {mem[k][maddr[k][7:0] + 8'd1], mem[k][maddr[k][7:0]]};

        wb_mem_bridge #(.WAIT_STATES((k == 0) ? 1 : ((k == 1) ? 0 : 3))) u_dut (
            .clk         (clk),
            .rst         (rst),
            .wb          (ifc),
            .mem_addr    (maddr[k]),
            .mem_wr_data (mwd[k]),
            .mem_rd_data (mrd[k]),
            .mem_we      (mwe[k]),
            .mem_byte_m  (mbm[k])
        );
    end

    // Memory model: byte writes use data[7:0], word writes fill addr and addr+1.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= 8'(i * 7 + 3);
            end else if (mwe[k]) begin
                mem[k][maddr[k][7:0]] <= mwd[k][7:0];
                if (!mbm[k]) mem[k][maddr[k][7:0] + 8'd1] <= mwd[k][15:8];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [1:0] s, input logic [18:0] a, input logic [15:0] d);
        we = w; sel = s; adr = a; dat = d; cyc = 1'b1; stb = 1'b1;
        lat = 0; wes = 0; a_addr = '0; a_wd = '0; a_bm = 1'b0; a_rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mwe[dut_sel]) wes++;
            if (ack[dut_sel]) begin
                lat = i; a_addr = maddr[dut_sel]; a_wd = mwd[dut_sel];
                a_bm = mbm[dut_sel]; a_rd = rdat[dut_sel];
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        if (mwe[dut_sel]) wes++;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] b2b_exp [4];
        int idx, acks, wecnt;
        b2b_exp[0] = 16'h0A03; b2b_exp[1] = 16'h1811; b2b_exp[2] = 16'h261F; b2b_exp[3] = 16'h342D;
        rst = 1'b1; mem_init = 1'b1; dut_sel = 0;
        adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);
        check_eq("rst_ack", ack[0], 0);
        check_eq("rst_we", mwe[0], 0);
        check_eq("rst_dat_o", rdat[0], 16'h0000);
        check_eq("rst_addr", maddr[0], 20'h00000);
        check_eq("rst_wdata", mwd[0], 16'h0000);
        check_eq("rst_byte_m", mbm[0], 0);
        @(posedge clk); #1;

        xfer(1'b1, 2'b11, 19'h78000, 16'hBEEF);
        check_eq("w16_lat", lat, 3);
        check_eq("w16_we_cycles", wes, 1);
        check_eq("w16_addr", a_addr, 20'hF0000);
        check_eq("w16_byte_m", a_bm, 0);
        check_eq("w16_mem0", mem[0][0], 8'hEF);
        check_eq("w16_mem1", mem[0][1], 8'hBE);

        xfer(1'b0, 2'b10, 19'h78000, 16'h0000);
        check_eq("rhi_lat", lat, 3);
        check_eq("rhi_we_cycles", wes, 0);
        check_eq("rhi_addr", a_addr, 20'hF0001);
        check_eq("rhi_byte_m", a_bm, 1);
        check_eq("rhi_data", a_rd, 16'hBE00);

        xfer(1'b0, 2'b01, 19'h78000, 16'h0000);
        check_eq("rlo_addr", a_addr, 20'hF0000);
        check_eq("rlo_data", a_rd, 16'h00EF);

        xfer(1'b1, 2'b10, 19'h78000, 16'h5AA5);
        check_eq("whi_we_cycles", wes, 1);
        check_eq("whi_addr", a_addr, 20'hF0001);
        check_eq("whi_wdata", a_wd[7:0], 8'h5A);
        check_eq("whi_mem1", mem[0][1], 8'h5A);
        check_eq("whi_mem0", mem[0][0], 8'hEF);
        check_eq("whi_dat_o_hold", rdat[0], 16'h00EF);

        xfer(1'b0, 2'b11, 19'h78000, 16'h0000);
        check_eq("r16_data", a_rd, 16'h5AEF);
        check_eq("r16_byte_m", a_bm, 0);

        xfer(1'b0, 2'b00, 19'h78000, 16'h0000);
        check_eq("rsel0_lat", lat, 3);
        check_eq("rsel0_data", a_rd, 16'h0000);

        // zero wait states, strobe held: ack every second cycle
        dut_sel = 1; idx = 0;
        we = 1'b0; sel = 2'b11; adr = 19'h0; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        check_eq("b2b_pre_ack", ack[1], 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("b2b_ack%0d", i), ack[1], (i % 2 == 0) ? 1 : 0);
            if (ack[1] && idx < 4) begin
                check_eq($sformatf("b2b_data%0d", idx), rdat[1], b2b_exp[idx]);
                idx++;
                if (i != 7) begin
                    @(posedge clk); #1;
                    adr = 19'(idx);
                end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        check_eq("b2b_acks", idx, 4);
        @(posedge clk); #1;

        dut_sel = 2;
        xfer(1'b0, 2'b11, 19'h0, 16'h0000);
        check_eq("ws3_rd_lat", lat, 5);
        check_eq("ws3_rd_data", a_rd, 16'h0A03);

        // abort in WAIT
        we = 1'b1; sel = 2'b11; adr = 19'h0; dat = 16'h1234; cyc = 1'b1; stb = 1'b1;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        acks = 0; wecnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ack[2]) acks++;
            if (mwe[2]) wecnt++;
        end
        check_eq("abort_acks", acks, 0);
        check_eq("abort_we", wecnt, 0);
        check_eq("abort_mem0", mem[2][0], 8'h03);
        check_eq("abort_mem1", mem[2][1], 8'h0A);
        @(posedge clk); #1;

        xfer(1'b1, 2'b11, 19'h1, 16'hC3D2);
        check_eq("ws3_wr_lat", lat, 5);
        check_eq("ws3_wr_we_cycles", wes, 1);
        check_eq("ws3_wr_mem2", mem[2][2], 8'hD2);
        check_eq("ws3_wr_mem3", mem[2][3], 8'hC3);

        // reset during WAIT of a write
        we = 1'b1; sel = 2'b11; adr = 19'h2; dat = 16'h7777; cyc = 1'b1; stb = 1'b1;
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("mrst_ack", ack[2], 0);
        check_eq("mrst_we", mwe[2], 0);
        check_eq("mrst_addr", maddr[2], 20'h00000);
        check_eq("mrst_wdata", mwd[2], 16'h0000);
        check_eq("mrst_byte_m", mbm[2], 0);
        check_eq("mrst_dat_o", rdat[2], 16'h0000);
        wecnt = 0; acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mwe[2]) wecnt++;
            if (ack[2]) acks++;
        end
        check_eq("mrst_no_we", wecnt, 0);
        check_eq("mrst_no_ack", acks, 0);
        check_eq("mrst_mem4", mem[2][4], 8'h1F);
        check_eq("mrst_mem5", mem[2][5], 8'h26);
        @(posedge clk); #1;

        xfer(1'b1, 2'b00, 19'h3, 16'hFFFF);
        check_eq("sel0_lat", lat, 5);
        check_eq("sel0_we_cycles", wes, 0);
        check_eq("sel0_mem6", mem[2][6], 8'h2D);
        check_eq("sel0_mem7", mem[2][7], 8'h34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_mem_bridge.md
WB_MEM_BRIDGE -- requirements
Module: wb_mem_bridge

Interface
REQ-001 Parameter: WAIT_STATES, default 1, number of idle cycles inserted between request capture and acknowledge; legal range 0..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wb_adr_i  input  19  Wishbone word address; byte address = {wb_adr_i, 1'b0}.
REQ-005 wb_dat_i  input  16  Wishbone write data.
REQ-006 wb_dat_o  output  16  Wishbone read data, registered.
REQ-007 wb_sel_i  input  2  byte lane select; bit 0 = low byte (even address), bit 1 = high byte (odd address).
REQ-008 wb_we_i  input  1  1 = write, 0 = read.
REQ-009 wb_stb_i  input  1  strobe.
REQ-010 wb_cyc_i  input  1  bus cycle valid.
REQ-011 wb_ack_o  output  1  single-cycle acknowledge.
REQ-012 mem_addr  output  20  byte address to the flat 1 MB memory port.
REQ-013 mem_wr_data  output  16  write data to memory; byte writes use bits [7:0] only.
REQ-014 mem_rd_data  input  16  combinational read data from memory; byte mode returns byte in [7:0], sign-extended in [15:8].
REQ-015 mem_we  output  1  memory write enable, sampled by memory on rising clk.
REQ-016 mem_byte_m  output  1  1 = byte access, 0 = 16-bit access at mem_addr/mem_addr+1.

Function
REQ-017 FSM states: IDLE, WAIT, ACK.
REQ-018 Request = wb_cyc_i & wb_stb_i sampled high in IDLE; on that edge the block SHALL latch adr, dat_i, sel, we and load wait counter with WAIT_STATES.
REQ-019 IDLE -> WAIT on request when WAIT_STATES > 0; IDLE -> ACK directly when WAIT_STATES = 0.
REQ-020 WAIT: counter decrements each cycle; WAIT -> ACK on the edge where counter reaches 0 (i.e. exactly WAIT_STATES cycles spent in WAIT).
REQ-021 ACK lasts exactly one cycle with wb_ack_o = 1, then -> IDLE unconditionally.
REQ-022 Latency: wb_ack_o high in cycle N+1+WAIT_STATES when request sampled at edge ending cycle N; minimum request-to-request period = WAIT_STATES+2 cycles.
REQ-023 Lane mapping from latched sel: 2'b11 -> mem_addr = {adr,0}, mem_byte_m = 0, mem_wr_data = dat_i; 2'b01 -> mem_addr = {adr,0}, mem_byte_m = 1, mem_wr_data[7:0] = dat_i[7:0]; 2'b10 -> mem_addr = {adr,1}, mem_byte_m = 1, mem_wr_data[7:0] = dat_i[15:8].
REQ-024 mem_addr, mem_byte_m, mem_wr_data SHALL hold latched values from request capture until return to IDLE.
REQ-025 mem_we SHALL be 1 only during the ACK cycle of a write with sel != 2'b00; exactly one write per transaction.
REQ-026 Read data: on the edge entering ACK, wb_dat_o SHALL load sel 11 -> mem_rd_data; sel 01 -> {8'h00, mem_rd_data[7:0]}; sel 10 -> {mem_rd_data[7:0], 8'h00}; sel 00 -> 16'h0000.
REQ-027 wb_dat_o SHALL hold its value until the next read enters ACK; writes do not alter it.
REQ-028 sel = 2'b00: transaction acknowledged normally, no memory write, read returns 0.
REQ-029 Abort: wb_cyc_i low in WAIT -> IDLE next edge, no ack, no mem_we; wb_cyc_i low during ACK does not suppress the ack already issued.
REQ-030 Back-to-back: request held high in the cycle after ACK is sampled as a new request in IDLE.
REQ-031 Inputs other than wb_cyc_i are ignored outside IDLE.
REQ-032 Address wrap: {adr,1} word access is not generated (sel 11 always even address); no wrap logic required.

Reset
REQ-033 rst high at a rising edge SHALL force state IDLE, counter 0, wb_ack_o 0, mem_we 0, wb_dat_o 16'h0000, mem_addr 20'h00000, mem_wr_data 16'h0000, mem_byte_m 0, overriding any transition in that cycle.
REQ-034 Reset mid-transaction SHALL discard it: no ack, no write after reset edge.

Verification
REQ-035 WAIT_STATES=1, word write adr 19'h78000 (byte 20'hF0000), sel 11, dat 16'hBEEF -> ack in 3rd cycle after request, mem_we one cycle, memory F0000=EF, F0001=BE.
REQ-036 Read back same address sel 10 -> mem_addr 20'hF0001, mem_byte_m 1, wb_dat_o 16'hBE00; sel 01 -> wb_dat_o 16'h00EF.
REQ-037 Byte write sel 10, dat 16'h5AA5 to 20'hF0000 word -> only F0001 = 5A, F0000 unchanged.
REQ-038 WAIT_STATES=0 back-to-back reads with stb held high -> ack every 2nd cycle, dat_o updated each ack.
REQ-039 Abort: write request then wb_cyc_i low in WAIT (WAIT_STATES=3) -> no ack, mem_we never 1, memory unchanged.
REQ-040 Reset asserted during WAIT of a write -> all outputs at reset values next cycle, no write occurs; sel 00 write afterwards -> ack, no mem_we.
